// File: rtl/memory_stream_pkg.sv
// Shared types for the memory stream reader: controller states and the
// depth of the address/data tag pipe.
package memory_stream_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_t;

    // Address register plus one cycle of registered memory read.
    localparam int TAG_STAGES = 2;

endpackage

// File: rtl/stream_fifo.sv
// Register-based FIFO with head/tail pointers; simultaneous push and pop
// are both honoured and leave occupancy unchanged.
module stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Head word is masked to zero while empty so the stream output is clean after reset.
    assign popData = empty ? '0 : storage[head];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) tail <= tail + PW'(1);
            if (doPop)  head <= head + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) storage[tail] <= pushData;
    end

endmodule

// File: rtl/memory_stream_reader.sv
// Reads count words starting at baseAddress from a 1-cycle synchronous-read
// memory and presents them as a valid/ready stream with full backpressure.
module memory_stream_reader #(
    parameter int DEPTH      = 1024,
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [AW-1:0]    baseAddress,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    memAddress,
    input  logic [WIDTH-1:0] memRead,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic             outLast
);

    import memory_stream_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reader_state_t             state;
    reader_state_t             stateNext;
    logic [AW:0]               remaining;
    logic [TAG_STAGES-1:0]     vld_p;
    logic [TAG_STAGES-1:0]     last_p;
    logic                      issue;
    logic                      issueLast;
    logic                      doneNext;
    logic                      creditOk;
    logic                      pop;
    logic [CW-1:0]             fifoCount;
    logic                      fifoEmpty;
    logic                      fifoFull;
    logic [WIDTH:0]            popData;

    function automatic logic [AW-1:0] nextAddress(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    // Words already buffered plus words still in the tag pipe must fit the FIFO.
    assign creditOk = (int'(fifoCount) + $countones(vld_p)) < FIFO_DEPTH;
    assign pop      = outValid && outReady;
    assign busy     = (state != IDLE);
    assign outValid = !fifoEmpty;
    assign outData  = popData[WIDTH-1:0];
    assign outLast  = popData[WIDTH];

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        issueLast = 1'b0;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        doneNext = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        issueLast = (count == (AW+1)'(1));
                        stateNext = issueLast ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (remaining != '0 && creditOk) begin
                    issue     = 1'b1;
                    issueLast = (remaining == (AW+1)'(1));
                    if (issueLast) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && outLast) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            done       <= 1'b0;
            remaining  <= '0;
            memAddress <= '0;
            vld_p      <= '0;
            last_p     <= '0;
        end else begin
            state  <= stateNext;
            done   <= doneNext;
            // Stage A: address registered; stage B: memory data available.
            vld_p  <= {vld_p[TAG_STAGES-2:0], issue};
            last_p <= {last_p[TAG_STAGES-2:0], issueLast};
            if (issue) begin
                if (state == IDLE) begin
                    memAddress <= baseAddress;
                    remaining  <= count - (AW+1)'(1);
                end else begin
                    memAddress <= nextAddress(memAddress);
                    remaining  <= remaining - (AW+1)'(1);
                end
            end
        end
    end

    stream_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (vld_p[TAG_STAGES-1]),
        .pushData ({last_p[TAG_STAGES-1], memRead}),
        .pop      (pop),
        .popData  (popData),
        .count    (fifoCount),
        .empty    (fifoEmpty),
        .full     (fifoFull)
    );

    // The credit rule means a capture never meets a full FIFO.
    always @(posedge clock) begin
        if (resetn && vld_p[TAG_STAGES-1]) assert (!fifoFull);
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed bench for memory_stream_reader with a behavioural synchronous-read
// memory holding mem[i] = i + 100.
module tb_memory_stream_reader;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 32;
    localparam int AW    = 10;

    logic             clock;
    logic             resetn;
    logic             start;
    logic [AW-1:0]    baseAddress;
    logic [AW:0]      count;
    logic             busy;
    logic             done;
    logic [AW-1:0]    memAddress;
    logic [WIDTH-1:0] memRead;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic             outLast;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] gotData [$];
    logic             gotLast [$];
    int               hsCyc   [$];
    int               addrLog [$];
    int               doneCyc;
    int               busyAtDone;
    int               maxOut;

    memory_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .baseAddress (baseAddress),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .memAddress  (memAddress),
        .memRead     (memRead),
        .outValid    (outValid),
        .outReady    (outReady),
        .outData     (outData),
        .outLast     (outLast)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) memRead <= mem[memAddress];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_transfer(input int base, input int n);
        start       = 1'b1;
        baseAddress = AW'(base);
        count       = (AW+1)'(n);
        tick();
        start = 1'b0;
    endtask

    // Runs the stream until done is seen; returns at the sample where done is high.
    task automatic stream(input int base, input int budget, input int readyPct, input int holdOff);
        int cyc;
        int outstanding;
        bit prevStall;
        logic [WIDTH-1:0] prevData;
        logic prevLast;
        gotData.delete();
        gotLast.delete();
        hsCyc.delete();
        addrLog.delete();
        doneCyc    = -1;
        busyAtDone = -1;
        maxOut     = 0;
        prevStall  = 1'b0;
        prevData   = '0;
        prevLast   = 1'b0;
        cyc        = 0;
        while (cyc < budget && doneCyc < 0) begin
            if (done) begin
                doneCyc    = cyc;
                busyAtDone = int'(busy);
            end else begin
                addrLog.push_back(int'(memAddress));
                outstanding = (int'(memAddress) - base + 1) - gotData.size();
                if (outstanding > maxOut) maxOut = outstanding;
                if (prevStall) begin
                    check("stall_valid", 32'(outValid), 32'd1);
                    check("stall_data", outData, prevData);
                    check("stall_last", 32'(outLast), 32'(prevLast));
                end
                outReady = (cyc >= holdOff) && (int'($urandom_range(99)) < readyPct);
                if (outValid && outReady) begin
                    gotData.push_back(outData);
                    gotLast.push_back(outLast);
                    hsCyc.push_back(cyc);
                end
                prevStall = outValid && !outReady;
                prevData  = outData;
                prevLast  = outLast;
                tick();
                cyc++;
            end
        end
        check("done_seen", 32'(doneCyc >= 0), 32'd1);
    endtask

    function automatic logic [15:0] last_bits();
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < gotLast.size() && i < 16; i++) b[i] = gotLast[i];
        return b;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
        resetn      = 1'b0;
        start       = 1'b0;
        baseAddress = '0;
        count       = '0;
        outReady    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(memAddress), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", outData, 32'd0);
        check("rst_last", 32'(outLast), 32'd0);
        resetn = 1'b1;
        tick();

        // Basic 4-word transfer, outReady high
        begin_transfer(5, 4);
        check("t1_addr0", 32'(memAddress), 32'd5);
        check("t1_busy", 32'(busy), 32'd1);
        stream(5, 100, 100, 0);
        check("t1_n", 32'(gotData.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t1_data", gotData[i], 32'(105 + i));
        check("t1_last", 32'(last_bits()), 32'h8);
        check("t1_first_cyc", 32'(hsCyc[0]), 32'd2);
        check("t1_last_cyc", 32'(hsCyc[3]), 32'd5);
        check("t1_done_cyc", 32'(doneCyc), 32'd6);
        check("t1_busy_done", 32'(busyAtDone), 32'd0);
        check("t1_maxout", 32'(maxOut), 32'd3);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Address wrap at the top of memory
        begin_transfer(1022, 4);
        stream(1022, 100, 100, 0);
        check("t2_a0", 32'(addrLog[0]), 32'd1022);
        check("t2_a1", 32'(addrLog[1]), 32'd1023);
        check("t2_a2", 32'(addrLog[2]), 32'd0);
        check("t2_a3", 32'(addrLog[3]), 32'd1);
        check("t2_d0", gotData[0], 32'd1122);
        check("t2_d1", gotData[1], 32'd1123);
        check("t2_d2", gotData[2], 32'd100);
        check("t2_d3", gotData[3], 32'd101);
        tick();

        // Backpressure: hold ready low long enough to fill, then 30% duty
        begin_transfer(200, 8);
        stream(200, 600, 30, 8);
        check("t3_n", 32'(gotData.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("t3_data", gotData[i], 32'(300 + i));
        check("t3_last", 32'(last_bits()), 32'h80);
        check("t3_maxout", 32'(maxOut), 32'd4);
        check("t3_stall_addr3", 32'(addrLog[3]), 32'd203);
        check("t3_stall_addr7", 32'(addrLog[7]), 32'd203);
        tick();

        // Zero-count start
        outReady = 1'b1;
        begin_transfer(9, 0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_valid", 32'(outValid), 32'd0);
        tick();
        check("t4_done_pulse", 32'(done), 32'd0);
        check("t4_valid2", 32'(outValid), 32'd0);

        // Back-to-back: B starts in A's done cycle
        begin_transfer(10, 3);
        stream(10, 100, 100, 0);
        check("t5a_d0", gotData[0], 32'd110);
        check("t5a_d1", gotData[1], 32'd111);
        check("t5a_d2", gotData[2], 32'd112);
        check("t5a_last", 32'(last_bits()), 32'h4);
        begin_transfer(50, 2);
        check("t5b_addr0", 32'(memAddress), 32'd50);
        stream(50, 100, 100, 0);
        check("t5b_n", 32'(gotData.size()), 32'd2);
        check("t5b_d0", gotData[0], 32'd150);
        check("t5b_d1", gotData[1], 32'd151);
        check("t5b_last", 32'(last_bits()), 32'h2);
        tick();

        // Reset mid-transfer after 2 of 6 words
        outReady = 1'b1;
        begin_transfer(0, 6);
        begin
            int taken;
            int guard;
            taken = 0;
            guard = 0;
            while (taken < 2 && guard < 50) begin
                if (outValid && outReady) taken++;
                tick();
                guard++;
            end
            check("t6_two_words", 32'(taken), 32'd2);
        end
        check("t6_valid_pre", 32'(outValid), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_valid", 32'(outValid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_addr", 32'(memAddress), 32'd0);
        check("t6_data", outData, 32'd0);
        tick();
        tick();
        check("t6_done_held", 32'(done), 32'd0);
        resetn = 1'b1;
        tick();
        check("t6_done_after", 32'(done), 32'd0);
        check("t6_valid_after", 32'(outValid), 32'd0);
        begin_transfer(7, 2);
        stream(7, 100, 100, 0);
        check("t6_n", 32'(gotData.size()), 32'd2);
        check("t6_d0", gotData[0], 32'd107);
        check("t6_d1", gotData[1], 32'd108);
        check("t6_last", 32'(last_bits()), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
